hex_key_entry: RTL and testbench
================================

Name: hex_key_entry

Overview:
- Converts the PS/2 scan-code byte stream from the keyboard receiver into hexadecimal digits.
- This is the input-side inverse of the 7-segment hex display path: a key glyph becomes a 4-bit value, where the display path turns a 4-bit value into a glyph.
- Tracks make, break and extended prefixes, and suppresses typematic repeats.
- Keeps a shift buffer of the last NUM_DIGITS entered digits, which feeds the per-digit hex displays and the game logic (entry/confirm).

Parameters:
- NUM_DIGITS, 4: depth of the digit buffer in nibbles (1..8).
- REPEAT_EN, 0: 1 = accept typematic repeats of a held key; 0 = one digit per physical press.

Ports:
- clock  in  1  system clock (50 MHz).
- reset  in  1  synchronous, active-high reset.
- scan_code  in  8  byte from the PS/2 receiver; valid only when scan_valid=1.
- scan_valid  in  1  single-cycle strobe, one per received byte.
- clear  in  1  synchronous buffer clear; the decode FSM is unaffected.
- digit  out  4  most recently accepted hex digit.
- digit_valid  out  1  1-cycle pulse when a digit is accepted.
- digits  out  4*NUM_DIGITS  digit buffer; newest digit in [3:0].
- count  out  4  number of valid digits in the buffer, 0..NUM_DIGITS.
- enter_pulse  out  1  1-cycle pulse on an Enter make.
- overflow  out  1  sticky flag: a digit was pushed while the buffer was full.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; held-key register = 8'h00.
- FSM states (advance only on scan_valid):
  - IDLE: E0 -> EXT; F0 -> BRK; any other byte is a make code -> IDLE.
  - EXT: F0 -> EXT_BRK; any other byte is an extended make -> IDLE.
  - BRK: any byte is a break code -> IDLE.
  - EXT_BRK: any byte is an extended break -> IDLE.
- Byte handling:
  - E0 or F0 arriving in BRK or EXT_BRK is treated as the released code, with no special meaning.
  - A byte of E1, AA, FA, EE, FE or 00 in IDLE is ignored and the FSM stays in IDLE.
- Digit map, scan set 2, non-extended makes:
  - Main row: 45=0, 16=1, 1E=2, 26=3, 25=4, 2E=5, 36=6, 3D=7, 3E=8, 46=9.
  - Letters: 1C=A, 32=B, 21=C, 23=D, 24=E, 2B=F.
  - Keypad: 70=0, 69=1, 72=2, 7A=3, 6B=4, 73=5, 74=6, 6C=7, 75=8, 7D=9.
- Control makes: 5A and E0 5A = Enter; 66 = Backspace; 76 = Esc.
- All other makes, including all extended makes other than 5A, are ignored.
- Repeat suppression (REPEAT_EN=0):
  - A make equal to the held-key register is ignored.
  - An accepted make loads the held-key register.
  - A break of the held code, extended or not, resets the register to 00.
  - A break of any other code leaves the register unchanged.
  - REPEAT_EN=1: every make is acted on.
- Latency: all outputs are registered. Effects appear on the cycle after the scan_valid that carries the final byte of the sequence.
- Digit accept:
  - digit <= value; digit_valid pulses.
  - digits <= {digits[4*NUM_DIGITS-5:0], value}.
  - count <= min(count+1, NUM_DIGITS).
  - If count==NUM_DIGITS before the push: the oldest nibble is discarded and overflow is set.
- Backspace:
  - digits <= {4'h0, digits[4*NUM_DIGITS-1:4]}.
  - count <= count-1, floored at 0.
  - At count==0: no change.
  - digit_valid does not pulse.
- Enter: enter_pulse pulses; the buffer is unchanged.
- Esc, or clear=1: digits, count and overflow are set to 0. digit holds its last value.
- Priority when clear coincides with an accepted key in the same cycle:
  - reset > clear > key action.
  - clear wins, and that key's pulses are still emitted.
- Reset during a multi-byte sequence: the FSM returns to IDLE and the partial sequence is discarded.
- scan_valid=0: state and buffer hold. Pulses are never wider than 1 cycle.

Decomposition:
- Shared keyboard package holds:
  - Prefix constants SC_EXT=8'hE0 and SC_BRK=8'hF0.
  - Key codes SC_ENTER, SC_BKSP and SC_ESC.
  - The FSM state enum.
- Sub-module scan_to_hex: combinational. Inputs: 8-bit code and ext flag. Outputs: is_hex, value[3:0], is_enter, is_bksp, is_esc.
- The FSM, repeat filter and buffer live in hex_key_entry.

Test Plan:
- Bytes 16, F0, 16, 1C, F0, 1C -> two digit_valid pulses (1, then A); digits[7:0]=8'h1A; count=2; pulse 1 cycle after the 16 and 1C bytes.
- REPEAT_EN=0, bytes 2E, 2E, 2E, F0, 2E, 2E -> exactly two pulses, both digit=5. With REPEAT_EN=1, the same stream gives four pulses.
- NUM_DIGITS=4, keys 1, 2, 3, 4, 5 -> digits=16'h2345; count=4; overflow=1. Then 66 (Backspace) -> digits=16'h0234; count=3; overflow stays 1.
- E0, 70 then E0, 5A -> no digit on the E0 70 sequence; one enter_pulse on E0 5A. A plain 70 afterwards -> digit=0.
- Bytes 16, then 76 -> count=0, digits=0, overflow=0, digit stays 1. Backspace at count=0 -> no change.
- reset asserted in the cycle after E0 F0, then byte 1E -> treated as a make in IDLE: digit=2, count=1.

Source files
------------

// File: rtl/hex_key_entry_pkg.sv
// Shared keyboard definitions: PS/2 scan-set-2 prefix and control codes,
// the decode FSM state type, and a helper that flags bytes with no key meaning.
package hex_key_entry_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_BKSP  = 8'h66;
  localparam logic [7:0] SC_ESC   = 8'h76;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } kbd_state_e;

  // Keyboard status/ack bytes and the pause prefix carry no key meaning here.
  function automatic logic is_noise(input logic [7:0] code);
    return (code == 8'hE1) || (code == 8'hAA) || (code == 8'hFA) ||
           (code == 8'hEE) || (code == 8'hFE) || (code == 8'h00);
  endfunction

endpackage

// File: rtl/hex_key_entry_scan_to_hex.sv
// Combinational key classifier: maps a make code (plus extended flag) to a
// hex nibble or to one of the Enter / Backspace / Esc control keys.
module scan_to_hex
  import hex_key_entry_pkg::*;
(
  input  logic [7:0] code_i,
  input  logic       ext_i,
  output logic       is_hex_o,
  output logic [3:0] value_o,
  output logic       is_enter_o,
  output logic       is_bksp_o,
  output logic       is_esc_o
);

  always_comb begin
    is_hex_o   = 1'b0;
    value_o    = 4'h0;
    is_enter_o = 1'b0;
    is_bksp_o  = 1'b0;
    is_esc_o   = 1'b0;
    if (ext_i) begin
      // Keypad Enter is the only extended key with a meaning here.
      is_enter_o = (code_i == SC_ENTER);
    end else begin
      is_hex_o = 1'b1;
      case (code_i)
        8'h45, 8'h70: value_o = 4'h0;
        8'h16, 8'h69: value_o = 4'h1;
        8'h1E, 8'h72: value_o = 4'h2;
        8'h26, 8'h7A: value_o = 4'h3;
        8'h25, 8'h6B: value_o = 4'h4;
        8'h2E, 8'h73: value_o = 4'h5;
        8'h36, 8'h74: value_o = 4'h6;
        8'h3D, 8'h6C: value_o = 4'h7;
        8'h3E, 8'h75: value_o = 4'h8;
        8'h46, 8'h7D: value_o = 4'h9;
        8'h1C:        value_o = 4'hA;
        8'h32:        value_o = 4'hB;
        8'h21:        value_o = 4'hC;
        8'h23:        value_o = 4'hD;
        8'h24:        value_o = 4'hE;
        8'h2B:        value_o = 4'hF;
        default:      is_hex_o = 1'b0;
      endcase
      is_enter_o = (code_i == SC_ENTER);
      is_bksp_o  = (code_i == SC_BKSP);
      is_esc_o   = (code_i == SC_ESC);
    end
  end

endmodule

// File: rtl/hex_key_entry.sv
// PS/2 scan-code to hex-digit entry: prefix-tracking decode FSM, typematic
// repeat filter and a shift buffer of the most recent NUM_DIGITS digits.
module hex_key_entry
  import hex_key_entry_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter bit REPEAT_EN  = 1'b0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [7:0]              scan_code,
  input  logic                    scan_valid,
  input  logic                    clear,
  output logic [3:0]              digit,
  output logic                    digit_valid,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [3:0]              count,
  output logic                    enter_pulse,
  output logic                    overflow
);

  localparam int         W    = 4 * NUM_DIGITS;
  localparam logic [3:0] FULL = 4'(NUM_DIGITS);

  kbd_state_e state_q, state_d;
  logic [7:0] held_q, held_d;
  logic [3:0] digit_q, digit_d;
  logic       dv_q, dv_d;
  logic [W-1:0] digits_q, digits_d;
  logic [3:0] count_q, count_d;
  logic       ent_q, ent_d;
  logic       ovf_q, ovf_d;

  logic       make_vld, brk_vld, ext;
  logic       is_hex, is_enter, is_bksp, is_esc;
  logic [3:0] key_val;
  logic       accept;

  scan_to_hex u_map (
    .code_i     (scan_code),
    .ext_i      (ext),
    .is_hex_o   (is_hex),
    .value_o    (key_val),
    .is_enter_o (is_enter),
    .is_bksp_o  (is_bksp),
    .is_esc_o   (is_esc)
  );

  always_comb begin
    state_d  = state_q;
    make_vld = 1'b0;
    brk_vld  = 1'b0;
    ext      = 1'b0;
    if (scan_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (scan_code == SC_EXT)      state_d = ST_EXT;
          else if (scan_code == SC_BRK) state_d = ST_BRK;
          else                          make_vld = !is_noise(scan_code);
        end
        ST_EXT: begin
          if (scan_code == SC_BRK) begin
            state_d = ST_EXT_BRK;
          end else begin
            state_d  = ST_IDLE;
            make_vld = 1'b1;
            ext      = 1'b1;
          end
        end
        default: begin
          // Any byte after F0, prefixes included, is the released key code.
          state_d = ST_IDLE;
          brk_vld = 1'b1;
        end
      endcase
    end
  end

  assign accept = make_vld && (is_hex || is_enter || is_bksp || is_esc) &&
                  (REPEAT_EN || (scan_code != held_q));

  always_comb begin
    held_d   = held_q;
    digit_d  = digit_q;
    dv_d     = 1'b0;
    digits_d = digits_q;
    count_d  = count_q;
    ent_d    = 1'b0;
    ovf_d    = ovf_q;
    if (accept) held_d = scan_code;
    if (brk_vld && (scan_code == held_q)) held_d = 8'h00;
    if (accept) begin
      if (is_hex) begin
        digit_d  = key_val;
        dv_d     = 1'b1;
        digits_d = (digits_q << 4) | W'(key_val);
        if (count_q == FULL) ovf_d = 1'b1;
        else                 count_d = count_q + 4'd1;
      end
      if (is_bksp && (count_q != 4'd0)) begin
        digits_d = digits_q >> 4;
        count_d  = count_q - 4'd1;
      end
      if (is_enter) ent_d = 1'b1;
      if (is_esc) begin
        digits_d = '0;
        count_d  = 4'd0;
        ovf_d    = 1'b0;
      end
    end
    // Clear overrides the buffer effect of a coincident key; its pulses remain.
    if (clear) begin
      digits_d = '0;
      count_d  = 4'd0;
      ovf_d    = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      held_q   <= 8'h00;
      digit_q  <= 4'h0;
      dv_q     <= 1'b0;
      digits_q <= '0;
      count_q  <= 4'd0;
      ent_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      held_q   <= held_d;
      digit_q  <= digit_d;
      dv_q     <= dv_d;
      digits_q <= digits_d;
      count_q  <= count_d;
      ent_q    <= ent_d;
      ovf_q    <= ovf_d;
    end
  end

  assign digit       = digit_q;
  assign digit_valid = dv_q;
  assign digits      = digits_q;
  assign count       = count_q;
  assign enter_pulse = ent_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_hex_key_entry.sv
// Bench for hex_key_entry: a repeat-suppressing and a repeat-accepting instance
// share one byte stream and are compared each cycle against a queue-based model.
module tb_hex_key_entry;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  scan_code = 8'h00;
  logic        scan_valid = 1'b0;
  logic        clear = 1'b0;

  logic [3:0]  digit0, digit1, count0, count1;
  logic        dv0, dv1, ent0, ent1, ovf0, ovf1;
  logic [15:0] digits0, digits1;

  int n_chk = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;
  bit cnt_en = 1'b0;
  int pulses0 = 0;
  int pulses1 = 0;

  always #10 clock = ~clock;

  hex_key_entry #(.NUM_DIGITS(4), .REPEAT_EN(1'b0)) dut (
    .clock(clock), .reset(reset), .scan_code(scan_code), .scan_valid(scan_valid),
    .clear(clear), .digit(digit0), .digit_valid(dv0), .digits(digits0),
    .count(count0), .enter_pulse(ent0), .overflow(ovf0)
  );

  hex_key_entry #(.NUM_DIGITS(4), .REPEAT_EN(1'b1)) dut_r (
    .clock(clock), .reset(reset), .scan_code(scan_code), .scan_valid(scan_valid),
    .clear(clear), .digit(digit1), .digit_valid(dv1), .digits(digits1),
    .count(count1), .enter_pulse(ent1), .overflow(ovf1)
  );

  // Model state, index 0 = repeats suppressed, index 1 = repeats accepted.
  int         mq [2][$];
  logic [3:0] m_digit [2];
  logic       m_dv [2];
  logic       m_ent [2];
  logic       m_ovf [2];
  logic [7:0] m_held [2];
  bit         saw_e0 [2];
  bit         saw_f0 [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [15:0] exp_digits(input int m);
    logic [15:0] r = 16'h0;
    for (int i = 0; i < mq[m].size(); i++) r = r | (16'(mq[m][i]) << (4 * i));
    return r;
  endfunction

  // kind: 0 none, 1 hex, 2 enter, 3 backspace, 4 esc
  task automatic classify(input logic [7:0] b, input bit e, output int kind, output logic [3:0] v);
    kind = 0;
    v = 4'h0;
    if (e) begin
      if (b == 8'h5A) kind = 2;
      return;
    end
    case (b)
      8'h45, 8'h70: begin kind = 1; v = 4'h0; end
      8'h16, 8'h69: begin kind = 1; v = 4'h1; end
      8'h1E, 8'h72: begin kind = 1; v = 4'h2; end
      8'h26, 8'h7A: begin kind = 1; v = 4'h3; end
      8'h25, 8'h6B: begin kind = 1; v = 4'h4; end
      8'h2E, 8'h73: begin kind = 1; v = 4'h5; end
      8'h36, 8'h74: begin kind = 1; v = 4'h6; end
      8'h3D, 8'h6C: begin kind = 1; v = 4'h7; end
      8'h3E, 8'h75: begin kind = 1; v = 4'h8; end
      8'h46, 8'h7D: begin kind = 1; v = 4'h9; end
      8'h1C: begin kind = 1; v = 4'hA; end
      8'h32: begin kind = 1; v = 4'hB; end
      8'h21: begin kind = 1; v = 4'hC; end
      8'h23: begin kind = 1; v = 4'hD; end
      8'h24: begin kind = 1; v = 4'hE; end
      8'h2B: begin kind = 1; v = 4'hF; end
      8'h5A: kind = 2;
      8'h66: kind = 3;
      8'h76: kind = 4;
      default: kind = 0;
    endcase
  endtask

  task automatic model_make(input int m, input logic [7:0] b, input bit e);
    int kind;
    logic [3:0] v;
    classify(b, e, kind, v);
    if (kind == 0) return;
    if (m == 0 && b == m_held[m]) return;
    m_held[m] = b;
    case (kind)
      1: begin
        m_digit[m] = v;
        m_dv[m] = 1'b1;
        mq[m].push_front(int'(v));
        if (mq[m].size() > 4) begin
          void'(mq[m].pop_back());
          m_ovf[m] = 1'b1;
        end
      end
      2: m_ent[m] = 1'b1;
      3: if (mq[m].size() > 0) void'(mq[m].pop_front());
      default: begin
        mq[m].delete();
        m_ovf[m] = 1'b0;
      end
    endcase
  endtask

  task automatic model_step(input int m);
    logic [7:0] b;
    m_dv[m] = 1'b0;
    m_ent[m] = 1'b0;
    if (reset) begin
      mq[m].delete();
      m_digit[m] = 4'h0;
      m_ovf[m] = 1'b0;
      m_held[m] = 8'h00;
      saw_e0[m] = 1'b0;
      saw_f0[m] = 1'b0;
      return;
    end
    if (scan_valid) begin
      b = scan_code;
      if (saw_f0[m]) begin
        if (b == m_held[m]) m_held[m] = 8'h00;
        saw_f0[m] = 1'b0;
        saw_e0[m] = 1'b0;
      end else if (saw_e0[m]) begin
        if (b == 8'hF0) saw_f0[m] = 1'b1;
        else begin
          saw_e0[m] = 1'b0;
          model_make(m, b, 1'b1);
        end
      end else if (b == 8'hE0) saw_e0[m] = 1'b1;
      else if (b == 8'hF0) saw_f0[m] = 1'b1;
      else if (!(b inside {8'hE1, 8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00})) model_make(m, b, 1'b0);
    end
    if (clear) begin
      mq[m].delete();
      m_ovf[m] = 1'b0;
    end
  endtask

  always @(posedge clock) begin
    model_step(0);
    model_step(1);
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("digit0", 32'(digit0), 32'(m_digit[0]));
      chk("dv0", 32'(dv0), 32'(m_dv[0]));
      chk("digits0", 32'(digits0), 32'(exp_digits(0)));
      chk("count0", 32'(count0), 32'(mq[0].size()));
      chk("enter0", 32'(ent0), 32'(m_ent[0]));
      chk("ovf0", 32'(ovf0), 32'(m_ovf[0]));
      chk("digit1", 32'(digit1), 32'(m_digit[1]));
      chk("dv1", 32'(dv1), 32'(m_dv[1]));
      chk("digits1", 32'(digits1), 32'(exp_digits(1)));
      chk("count1", 32'(count1), 32'(mq[1].size()));
      chk("enter1", 32'(ent1), 32'(m_ent[1]));
      chk("ovf1", 32'(ovf1), 32'(m_ovf[1]));
    end
    if (cnt_en) begin
      if (dv0) pulses0++;
      if (dv1) pulses1++;
    end
  end

  task automatic send(input logic [7:0] b, input bit clr = 1'b0);
    @(negedge clock);
    scan_code = b;
    scan_valid = 1'b1;
    clear = clr;
    @(negedge clock);
    scan_valid = 1'b0;
    clear = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    chk_en = 1'b1;
    chk("rst_digit", 32'(digit0), 32'h0);
    chk("rst_digits", 32'(digits0), 32'h0);
    chk("rst_count", 32'(count0), 32'h0);
    chk("rst_ovf", 32'(ovf0), 32'h0);

    // Two keys with breaks between.
    send(8'h16);
    chk("t1_dv_1", 32'(dv0), 32'h1);
    chk("t1_digit_1", 32'(digit0), 32'h1);
    send(8'hF0); send(8'h16);
    send(8'h1C);
    chk("t1_dv_A", 32'(dv0), 32'h1);
    chk("t1_digit_A", 32'(digit0), 32'hA);
    send(8'hF0); send(8'h1C);
    chk("t1_digits", 32'(digits0[7:0]), 32'h1A);
    chk("t1_count", 32'(count0), 32'h2);
    chk("t1_model", 32'(exp_digits(0)), 32'h1A);
    send(8'h76);
    chk("t1_esc_count", 32'(count0), 32'h0);

    // Typematic repeat stream.
    cnt_en = 1'b1;
    send(8'h2E); send(8'h2E); send(8'h2E); send(8'hF0); send(8'h2E); send(8'h2E);
    @(negedge clock);
    cnt_en = 1'b0;
    chk("t2_pulses_norep", 32'(pulses0), 32'd2);
    chk("t2_pulses_rep", 32'(pulses1), 32'd4);
    chk("t2_digit", 32'(digit0), 32'h5);
    send(8'hF0); send(8'h2E);
    send(8'h00, 1'b1);

    // Overflow then backspace.
    send(8'h16); send(8'h1E); send(8'h26); send(8'h25); send(8'h2E);
    chk("t3_digits", 32'(digits0), 32'h2345);
    chk("t3_count", 32'(count0), 32'h4);
    chk("t3_ovf", 32'(ovf0), 32'h1);
    chk("t3_model", 32'(exp_digits(0)), 32'h2345);
    send(8'h66);
    chk("t3_bs_digits", 32'(digits0), 32'h0234);
    chk("t3_bs_count", 32'(count0), 32'h3);
    chk("t3_bs_ovf", 32'(ovf0), 32'h1);

    // Extended keys.
    send(8'hE0); send(8'h70);
    chk("t4_ext70_dv", 32'(dv0), 32'h0);
    send(8'hE0); send(8'h5A);
    chk("t4_enter", 32'(ent0), 32'h1);
    chk("t4_enter_digits", 32'(digits0), 32'h0234);
    send(8'h70);
    chk("t4_kp0_dv", 32'(dv0), 32'h1);
    chk("t4_kp0_digit", 32'(digit0), 32'h0);

    // Esc, then backspace on an empty buffer.
    send(8'h16); send(8'h76);
    chk("t5_count", 32'(count0), 32'h0);
    chk("t5_digits", 32'(digits0), 32'h0);
    chk("t5_ovf", 32'(ovf0), 32'h0);
    chk("t5_digit", 32'(digit0), 32'h1);
    send(8'h66);
    chk("t5_bs_count", 32'(count0), 32'h0);
    chk("t5_bs_digits", 32'(digits0), 32'h0);

    // Reset in the middle of an extended break.
    send(8'hE0); send(8'hF0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    send(8'h1E);
    chk("t6_digit", 32'(digit0), 32'h2);
    chk("t6_count", 32'(count0), 32'h1);

    // Noise byte, then clear coinciding with a key.
    send(8'hAA);
    chk("t7_noise_dv", 32'(dv0), 32'h0);
    send(8'h1C);
    chk("t7_digits", 32'(digits0), 32'h002A);
    send(8'h3E, 1'b1);
    chk("t7_clr_dv", 32'(dv0), 32'h1);
    chk("t7_clr_digit", 32'(digit0), 32'h8);
    chk("t7_clr_count", 32'(count0), 32'h0);
    send(8'h7D);
    chk("t7_kp9", 32'(digits0), 32'h0009);
    repeat (3) @(negedge clock);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
